// File: rtl/i2c_pkg.sv
// Shared types and constants for the upstream I2C master and its bench.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WDATA,
    WACK,
    RDATA,
    MACK,
    STOP
  } i2c_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic [6:0] I2C_ADDR_S1 = 7'h48;
  localparam logic [6:0] I2C_ADDR_S2 = 7'h49;

endpackage

// File: rtl/i2c_quarter_tick.sv
// Divides clk into SCL quarter periods: one-cycle tick on the last cycle of
// each quarter plus a free-running 2-bit quarter index; held cleared while idle.
module i2c_quarter_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  output logic       tick,
  output logic [1:0] quarter
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      quarter <= 2'd0;
    end else if (clear) begin
      cnt     <= RELOAD;
      quarter <= 2'd0;
    end else if (cnt == '0) begin
      cnt     <= RELOAD;
      quarter <= quarter + 2'd1;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = !clear && (cnt == '0);

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-master I2C controller: one START/addr/data/STOP transfer per command,
// push-pull SCL and open-drain SDA (sda_oe=1 pulls the line low).
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_wdata,
  output logic [7:0] rd_data,
  output logic       done,
  output logic       nack,
  output logic       busy,
  output logic       scl,
  output logic       sda_oe,
  input  logic       sda_in
);

  i2c_state_t state_q, state_n;
  logic       tick;
  logic [1:0] quarter;
  logic [3:0] bit_cnt;
  logic [7:0] sh;
  logic [7:0] wdata_q;
  logic       rw_q;
  logic       sda_q;
  logic       ack_status;
  logic       handshake;
  logic       slot_end;
  logic       last_bit;

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == IDLE),
    .tick    (tick),
    .quarter (quarter)
  );

  assign cmd_ready = !busy;
  assign handshake = cmd_valid && !busy && (state_q == IDLE);
  assign slot_end  = tick && (quarter == 2'd3);
  assign last_bit  = (bit_cnt == 4'd7);

  always_comb begin
    scl = 1'b1;
    if (state_q != IDLE && state_q != START)
      scl = quarter[1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_q <= IDLE;
    else
      state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:     if (handshake) state_n = START;
      START:    if (slot_end) state_n = ADDR;
      ADDR:     if (slot_end && last_bit) state_n = ADDR_ACK;
      ADDR_ACK: if (slot_end) begin
                  if (sda_q == I2C_NACK) state_n = STOP;
                  else if (rw_q)         state_n = RDATA;
                  else                   state_n = WDATA;
                end
      WDATA:    if (slot_end && last_bit) state_n = WACK;
      WACK:     if (slot_end) state_n = STOP;
      RDATA:    if (slot_end && last_bit) state_n = MACK;
      MACK:     if (slot_end) state_n = STOP;
      STOP:     if (slot_end) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // Status is collected in ack_status and only published to nack with done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt    <= 4'd0;
      sh         <= 8'h00;
      wdata_q    <= 8'h00;
      rw_q       <= 1'b0;
      sda_q      <= 1'b0;
      ack_status <= 1'b0;
      rd_data    <= 8'h00;
      done       <= 1'b0;
      nack       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (done)
        busy <= 1'b0;
      if (handshake) begin
        sh         <= {cmd_addr, cmd_rw};
        wdata_q    <= cmd_wdata;
        rw_q       <= cmd_rw;
        bit_cnt    <= 4'd0;
        ack_status <= I2C_ACK;
        busy       <= 1'b1;
      end
      if (tick && quarter == 2'd2) begin
        sda_q <= sda_in;
        if (state_q == RDATA)
          sh <= {sh[6:0], sda_in};
      end
      if (slot_end) begin
        if (state_q == ADDR || state_q == WDATA || state_q == RDATA)
          bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
        case (state_q)
          ADDR, WDATA: sh <= {sh[6:0], 1'b0};
          ADDR_ACK: begin
            if (sda_q == I2C_NACK) ack_status <= I2C_NACK;
            else if (!rw_q)        sh <= wdata_q;
          end
          WACK:  ack_status <= sda_q;
          RDATA: if (last_bit) rd_data <= sh;
          MACK:  ack_status <= I2C_ACK;
          STOP: begin
            done <= 1'b1;
            nack <= ack_status;
          end
          default: ;
        endcase
      end
    end
  end

  // SDA only moves while SCL is low, except the START fall and STOP rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sda_oe <= 1'b0;
    end else begin
      if (state_q == START && tick && quarter == 2'd1)
        sda_oe <= 1'b1;
      else if (state_q == STOP && tick && quarter == 2'd2)
        sda_oe <= 1'b0;
      else if (tick && quarter == 2'd0) begin
        case (state_q)
          ADDR, WDATA:                sda_oe <= ~sh[7];
          ADDR_ACK, WACK, RDATA, MACK: sda_oe <= 1'b0;
          default: ;
        endcase
      end
      if (slot_end && state_n == STOP && state_q != STOP)
        sda_oe <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl at CLK_DIV=4 with a slot-timed slave model.
module tb_i2c_master_ctrl;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_addr;
  logic       cmd_rw;
  logic [7:0] cmd_wdata;
  logic [7:0] rd_data;
  logic       done, nack, busy, scl, sda_oe;
  logic       sda_in;
  logic       slave_low;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic bus_bits [0:19];
  int n_start, n_stop, n_scl_rise, mack_drive, hs_cyc;
  logic nack_mid;
  logic hold_mode = 1'b0;
  logic [6:0] hold_addr;
  logic hold_rw;
  logic [7:0] hold_wdata;

  i2c_master_ctrl #(.CLK_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_rw    (cmd_rw),
    .cmd_wdata (cmd_wdata),
    .rd_data   (rd_data),
    .done      (done),
    .nack      (nack),
    .busy      (busy),
    .scl       (scl),
    .sda_oe    (sda_oe),
    .sda_in    (sda_in)
  );

  assign sda_in = !(sda_oe || slave_low);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] bits_to_byte(input int first);
    logic [7:0] b = 8'h00;
    for (int i = 0; i < 8; i++) b = {b[6:0], bus_bits[first + i]};
    return b;
  endfunction

  // Issues one command and follows it edge by edge; slot k spans edges 16k..16k+15.
  task automatic run_xfer(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                          input logic ack_a, input logic ack_d, input logic [7:0] rb,
                          input int max_e, output int done_e);
    int slot, wait_n;
    logic cur_sda, prev_sda, prev_scl;
    done_e = -1; mack_drive = 0; n_scl_rise = 0; wait_n = 0;
    for (int i = 0; i < 20; i++) bus_bits[i] = 1'bx;
    cmd_addr = a; cmd_rw = rw; cmd_wdata = wd; cmd_valid = 1'b1;
    while (!cmd_ready && wait_n < 1000) begin @(posedge clk); #1; wait_n++; end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("[TB] FAIL handshake_timeout cmd_ready=%b required 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    hs_cyc = cyc;
    if (hold_mode) begin
      cmd_addr = hold_addr; cmd_rw = hold_rw; cmd_wdata = hold_wdata;
    end else cmd_valid = 1'b0;
    prev_scl = scl; prev_sda = !(sda_oe || slave_low);
    for (int e = 1; e <= max_e; e++) begin
      @(posedge clk); #1;
      slot = e / 16;
      slave_low = 1'b0;
      if (slot == 9) slave_low = ack_a;
      else if (ack_a && rw && slot >= 10 && slot <= 17) slave_low = ~rb[3'(17 - slot)];
      else if (ack_a && !rw && slot == 18) slave_low = ack_d;
      cur_sda = !(sda_oe || slave_low);
      if (prev_scl && scl && cur_sda != prev_sda) begin
        if (!cur_sda) n_start++; else n_stop++;
      end
      if (!prev_scl && scl) n_scl_rise++;
      if (e % 16 == 10 && slot < 20) bus_bits[slot] = cur_sda;
      if (rw && slot == 18 && sda_oe) mack_drive++;
      if (e == 100) nack_mid = nack;
      prev_scl = scl; prev_sda = cur_sda;
      if (done) begin done_e = e; break; end
    end
    slave_low = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; cmd_valid = 1'b0; slave_low = 1'b0;
    cmd_addr = 7'h00; cmd_rw = 1'b0; cmd_wdata = 8'h00;
    repeat (3) @(posedge clk); #1;
    checks++; if (scl !== 1'b1) begin errors++; $display("[TB] FAIL reset_scl got %b expected 1", scl); end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_sda_oe got %b expected 0", sda_oe); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b expected 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b expected 0", done); end
    checks++; if (nack !== 1'b0) begin errors++; $display("[TB] FAIL reset_nack got %b expected 0", nack); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_rd_data got %h expected 00", rd_data); end
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++; if (scl !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_after_release scl=%b busy=%b expected 1/0", scl, busy); end
  endtask

  task automatic test_write_ack;
    int de;
    run_xfer(I2C_ADDR_S1, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 400, de);
    checks++; if (de != 320) begin errors++; $display("[TB] FAIL write_done_cycle got %0d expected 320", de); end
    checks++; if (nack !== 1'b0) begin errors++; $display("[TB] FAIL write_nack got %b expected 0", nack); end
    checks++; if (bits_to_byte(1) !== 8'h90) begin errors++; $display("[TB] FAIL write_addr_bits got %h expected 90", bits_to_byte(1)); end
    checks++; if (bus_bits[9] !== 1'b0) begin errors++; $display("[TB] FAIL write_addr_ack got %b expected 0", bus_bits[9]); end
    checks++; if (bits_to_byte(10) !== 8'hA5) begin errors++; $display("[TB] FAIL write_data_bits got %h expected a5", bits_to_byte(10)); end
    checks++; if (n_scl_rise != 19) begin errors++; $display("[TB] FAIL write_scl_pulses got %0d expected 19", n_scl_rise); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL ready_during_done got %b expected 0", cmd_ready); end
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL ready_after_done ready=%b done=%b expected 1/0", cmd_ready, done); end
  endtask

  task automatic test_read_ack;
    int de;
    run_xfer(I2C_ADDR_S2, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C, 400, de);
    checks++; if (de != 320) begin errors++; $display("[TB] FAIL read_done_cycle got %0d expected 320", de); end
    checks++; if (rd_data !== 8'h3C) begin errors++; $display("[TB] FAIL read_rd_data got %h expected 3c", rd_data); end
    checks++; if (nack !== 1'b0) begin errors++; $display("[TB] FAIL read_nack got %b expected 0", nack); end
    checks++; if (bits_to_byte(1) !== 8'h93) begin errors++; $display("[TB] FAIL read_addr_bits got %h expected 93", bits_to_byte(1)); end
    checks++; if (bits_to_byte(10) !== 8'h3C) begin errors++; $display("[TB] FAIL read_bus_bits got %h expected 3c", bits_to_byte(10)); end
    checks++; if (mack_drive != 0 || bus_bits[18] !== 1'b1) begin errors++; $display("[TB] FAIL read_mack_release drives=%0d sda=%b expected 0/1", mack_drive, bus_bits[18]); end
  endtask

  task automatic test_addr_nack;
    int de;
    run_xfer(7'h50, 1'b0, 8'hFF, 1'b0, 1'b1, 8'h00, 400, de);
    checks++; if (de != 176) begin errors++; $display("[TB] FAIL nack_done_cycle got %0d expected 176", de); end
    checks++; if (nack !== 1'b1) begin errors++; $display("[TB] FAIL nack_status got %b expected 1", nack); end
    checks++; if (bits_to_byte(1) !== 8'hA0) begin errors++; $display("[TB] FAIL nack_addr_bits got %h expected a0", bits_to_byte(1)); end
    checks++; if (bus_bits[9] !== 1'b1) begin errors++; $display("[TB] FAIL nack_ack_slot got %b expected 1", bus_bits[9]); end
    checks++; if (n_scl_rise != 10) begin errors++; $display("[TB] FAIL nack_scl_pulses got %0d expected 10", n_scl_rise); end
    checks++; if (rd_data !== 8'h3C) begin errors++; $display("[TB] FAIL nack_rd_data_held got %h expected 3c", rd_data); end
  endtask

  task automatic test_reset_mid;
    int de;
    run_xfer(I2C_ADDR_S1, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 16 * 13 + 6, de);
    checks++; if (nack_mid !== 1'b1) begin errors++; $display("[TB] FAIL nack_held_mid got %b expected 1", nack_mid); end
    checks++; if (busy !== 1'b1 || sda_oe !== 1'b1 || scl !== 1'b0) begin errors++; $display("[TB] FAIL pre_reset busy=%b sda_oe=%b scl=%b expected 1/1/0", busy, sda_oe, scl); end
    #2 reset = 1'b0;
    #1;
    checks++; if (scl !== 1'b1) begin errors++; $display("[TB] FAIL midreset_scl got %b expected 1", scl); end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL midreset_sda_oe got %b expected 0", sda_oe); end
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_busy busy=%b ready=%b expected 0/1", busy, cmd_ready); end
    checks++; if (nack !== 1'b0 || rd_data !== 8'h00) begin errors++; $display("[TB] FAIL midreset_status nack=%b rd_data=%h expected 0/00", nack, rd_data); end
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    run_xfer(I2C_ADDR_S1, 1'b0, 8'hC3, 1'b1, 1'b1, 8'h00, 400, de);
    checks++; if (de != 320) begin errors++; $display("[TB] FAIL postreset_done got %0d expected 320", de); end
    checks++; if (bits_to_byte(10) !== 8'hC3 || nack !== 1'b0) begin errors++; $display("[TB] FAIL postreset_write data=%h nack=%b expected c3/0", bits_to_byte(10), nack); end
  endtask

  task automatic test_back_to_back;
    int de1, de2, first_done;
    hold_mode = 1'b1; hold_addr = I2C_ADDR_S2; hold_rw = 1'b0; hold_wdata = 8'h22;
    run_xfer(I2C_ADDR_S1, 1'b0, 8'h11, 1'b1, 1'b1, 8'h00, 400, de1);
    first_done = cyc;
    checks++; if (de1 != 320) begin errors++; $display("[TB] FAIL b2b_first_done got %0d expected 320", de1); end
    checks++; if (bits_to_byte(1) !== 8'h90 || bits_to_byte(10) !== 8'h11) begin errors++; $display("[TB] FAIL b2b_first_bytes addr=%h data=%h expected 90/11", bits_to_byte(1), bits_to_byte(10)); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_at_done got %b expected 0", cmd_ready); end
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_next got %b expected 1", cmd_ready); end
    hold_mode = 1'b0;
    run_xfer(I2C_ADDR_S2, 1'b0, 8'h22, 1'b1, 1'b1, 8'h00, 400, de2);
    checks++; if (hs_cyc != first_done + 2) begin errors++; $display("[TB] FAIL b2b_accept_cycle got %0d expected %0d", hs_cyc, first_done + 2); end
    checks++; if (de2 != 320) begin errors++; $display("[TB] FAIL b2b_second_done got %0d expected 320", de2); end
    checks++; if (bits_to_byte(1) !== 8'h92 || bits_to_byte(10) !== 8'h22) begin errors++; $display("[TB] FAIL b2b_second_bytes addr=%h data=%h expected 92/22", bits_to_byte(1), bits_to_byte(10)); end
  endtask

  task automatic test_protocol_random;
    int de, exp_len;
    logic [6:0] a;
    logic rw, ack_a, ack_d, exp_nack;
    logic [7:0] wd, rb;
    n_start = 0; n_stop = 0;
    for (int n = 0; n < 100; n++) begin
      a = 7'($urandom_range(0, 127)); rw = 1'($urandom_range(0, 1));
      wd = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255));
      ack_a = ($urandom_range(0, 3) != 0); ack_d = 1'($urandom_range(0, 1));
      run_xfer(a, rw, wd, ack_a, ack_d, rb, 400, de);
      exp_len = ack_a ? 320 : 176;
      exp_nack = !ack_a ? 1'b1 : (rw ? 1'b0 : !ack_d);
      checks++; if (de != exp_len) begin errors++; $display("[TB] FAIL rand_done_cycle n=%0d got %0d expected %0d", n, de, exp_len); end
      checks++; if (nack !== exp_nack) begin errors++; $display("[TB] FAIL rand_nack n=%0d got %b expected %b", n, nack, exp_nack); end
      checks++; if (bits_to_byte(1) !== {a, rw}) begin errors++; $display("[TB] FAIL rand_addr_bits n=%0d got %h expected %h", n, bits_to_byte(1), {a, rw}); end
      if (ack_a && rw) begin
        checks++; if (rd_data !== rb) begin errors++; $display("[TB] FAIL rand_rd_data n=%0d got %h expected %h", n, rd_data, rb); end
      end
    end
    checks++; if (n_start != 100) begin errors++; $display("[TB] FAIL protocol_starts got %0d expected 100", n_start); end
    checks++; if (n_stop != 100) begin errors++; $display("[TB] FAIL protocol_stops got %0d expected 100", n_stop); end
  endtask

  initial begin
    test_reset();
    test_write_ack();
    test_read_ack();
    test_addr_nack();
    test_reset_mid();
    test_back_to_back();
    test_protocol_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_master_ctrl.md
# i2c_master_ctrl

Single-master I2C controller that generates the upstream `scl`/`sda` bus feeding the I2C address translator. It accepts one command at a time over a valid/ready handshake and performs one complete transfer per command: START, 7-bit address, R/W bit, one data byte, STOP. A read returns the byte on `rd_data`. Every transfer reports an ACK/NACK status.

## Interface
- `CLK_DIV`, default 4: clk cycles per SCL quarter-period; must be ≥ 2. One bit period is 4·CLK_DIV cycles.
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  controller can accept a command (equals not busy)
- `cmd_addr`  in  7  target 7-bit address
- `cmd_rw`  in  1  0 = write, 1 = read
- `cmd_wdata`  in  8  write byte
- `rd_data`  out  8  last read byte; held until the next read completes
- `done`  out  1  one-cycle pulse at transfer end
- `nack`  out  1  status of the last transfer; valid with `done`, held until the next `done`
- `busy`  out  1  transfer in progress
- `scl`  out  1  bus clock, push-pull
- `sda_oe`  out  1  1 = drive SDA low; 0 = release (open-drain)
- `sda_in`  in  1  sampled SDA line

## Operation
**Reset values:** `scl`=1, `sda_oe`=0, `cmd_ready`=1, `busy`=0, `done`=0, `nack`=0, `rd_data`=0x00, FSM in IDLE, quarter counter 0.

**Command acceptance**
- A handshake occurs when `cmd_valid` and `cmd_ready` are both high on a rising clk edge.
- On handshake, the controller latches `{addr, rw}` into the 8-bit shift register `sh`, latches `cmd_wdata`, and sets `busy`=1.
- `cmd_valid` while busy is ignored.

**FSM states:** IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, MACK, STOP.
- IDLE → START on handshake.
- START → ADDR.
- ADDR: 8 bits, MSB first.
- ADDR → ADDR_ACK.
- ADDR_ACK:
  - SDA sampled 1 (NACK) → STOP, with `nack`=1.
  - SDA sampled 0 and rw=0 → WDATA.
  - SDA sampled 0 and rw=1 → RDATA.
- WDATA → WACK after 8 bits.
- WACK → STOP; `nack` is set to the sampled SDA value.
- RDATA → MACK after 8 bits; shift `sda_in` into `rd_data` LSB first-in (final byte is MSB-first order).
- MACK: the master releases SDA (NACK) to end the read → STOP; `nack`=0.
- STOP → IDLE: pulse `done`, clear `busy`.

**Bus rules**
- Master transmit bit 0 → `sda_oe`=1; bit 1 → `sda_oe`=0.
- During ADDR_ACK, WACK and RDATA, `sda_oe`=0.
- No clock stretching, no arbitration, no repeated START: the bus has a single master.

**Mid-operation reset:** outputs return to their reset values on the assertion edge, without waiting for a clock; the bus is released immediately.

## Timing
- Each FSM state except IDLE lasts 4 quarters (Q0–Q3) per bit; each quarter is CLK_DIV cycles.
- Data bit slot:
  - `scl` is low during Q0–Q1 and high during Q2–Q3.
  - `sda_oe` updates at the start of Q1.
  - `sda_in` is sampled at the last cycle of Q2.
- START slot: `scl`=1 throughout. SDA is released in Q0–Q1 and driven low in Q2–Q3. `scl` then falls entering ADDR Q0.
- STOP slot: SDA is driven low in Q0–Q2 and released in Q3. `scl` is 0 in Q0–Q1 and 1 in Q2–Q3.
- Full transfer length: (1 + 9 + 9 + 1) slots × 4·CLK_DIV cycles. With CLK_DIV=4 this is 320 cycles from handshake to `done`.
- Address-NACK transfer length: 11 slots (176 cycles at CLK_DIV=4).
- `cmd_ready` returns high on the cycle after the `done` pulse. A back-to-back command can be accepted in that same cycle.

## Structure
- Shared package `i2c_pkg`:
  - FSM state enum.
  - Constants `I2C_ACK`=0 and `I2C_NACK`=1.
  - Translator target addresses `I2C_ADDR_S1`=7'h48 and `I2C_ADDR_S2`=7'h49.
- Sub-module `i2c_quarter_tick`: down-counter that emits a one-cycle tick every CLK_DIV cycles and a 2-bit quarter index. It clears on reset and when in IDLE.
- Top level contains the FSM, the 4-bit bit counter, the shift register, and the status registers.

## Test plan
- **Write with ACK:** CLK_DIV=4, write addr 0x48, data 0xA5; the slave model ACKs both bytes.
  - SDA bits 1001000_0, then 10100101.
  - `done` asserts at cycle 320; `nack`=0.
- **Read with ACK:** read addr 0x49; the slave ACKs and drives 0x3C.
  - `rd_data`=0x3C.
  - SDA is released in the MACK slot.
  - `nack`=0; `done` at cycle 320.
- **Address NACK:** write addr 0x50; nobody ACKs.
  - No data slot occurs; STOP follows ADDR_ACK.
  - `done` at cycle 176 with `nack`=1.
- **Command while busy:** hold `cmd_valid` high with addr 0x49 while a transfer is busy.
  - It is ignored until `done`.
  - It is accepted the cycle after `done`; the second START begins with no idle gap beyond 1 cycle.
- **Reset mid-transfer:** assert `reset` during WDATA bit 3.
  - `scl`=1 and `sda_oe`=0 immediately; `busy`=0.
  - After release, a new write to 0x48 completes normally.
- **Protocol check:** SDA never changes while SCL is high, except in the START and STOP slots. The check passes across 100 random commands.
